// File: rtl/ir_pkg.sv
// Shared types, default timing constants and channel-selection helper
// for the IR reflectance sensor scan controller.
package ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCH,
    S_MEAS,
    S_STORE,
    S_NEXT
  } state_t;

  // 1.3 us discharge and ~655 us window at 50 MHz
  localparam int DISCH_CYC  = 65;
  localparam int WINDOW_CYC = 32750;
  localparam int SHIFT      = 3;

  typedef struct packed {
    logic found;
    int   idx;
  } ch_sel_t;

  // Lowest set bit of mask strictly above cur; cur = -1 yields the lowest set bit.
  function automatic ch_sel_t next_ch(input logic [31:0] mask, input int cur);
    ch_sel_t r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i > cur)) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Shared phase counter (discharge length / measurement window) and saturating
// high-time counter, time-multiplexed across all sensor channels.
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter int CNTW       = 16,
  parameter int DISCH_CYC  = ir_pkg::DISCH_CYC,
  parameter int WINDOW_CYC = ir_pkg::WINDOW_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            disch_en,
  input  logic            meas_en,
  input  logic            clr,
  input  logic            s_bit,
  output logic            disch_end,
  output logic            meas_end,
  output logic            meas_tmo,
  output logic [CNTW-1:0] cnt
);

  logic [CNTW-1:0] ph;
  logic            win_hit;

  assign disch_end = disch_en && (ph == CNTW'(DISCH_CYC - 1));
  assign win_hit   = meas_en && (ph == CNTW'(WINDOW_CYC - 1));
  // A low pin on the window's last cycle is an ordinary end, not a timeout
  assign meas_end  = meas_en && (!s_bit || win_hit);
  assign meas_tmo  = win_hit && s_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph  <= '0;
      cnt <= '0;
    end else begin
      if (!(disch_en || meas_en) || disch_end || meas_end) begin
        ph <= '0;
      end else if (ph != '1) begin
        ph <= ph + CNTW'(1);
      end

      if (clr) begin
        cnt <= '0;
      end else if (meas_en && s_bit && (cnt != '1)) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/ir_scan_ctrl.sv
// Round-robin RC-discharge IR sensor scanner: discharges each enabled pin,
// times how long it stays high and keeps a scaled 8-bit result per channel.
module ir_scan_ctrl
  import ir_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CHW        = 2,
  parameter int CNTW       = 16,
  parameter int DISCH_CYC  = ir_pkg::DISCH_CYC,
  parameter int WINDOW_CYC = ir_pkg::WINDOW_CYC,
  parameter int SHIFT      = ir_pkg::SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] ir_in,
  output logic [NCH-1:0] ir_oe,
  output logic [NCH-1:0] ir_out,
  output logic           busy,
  output logic           done,
  input  logic [CHW-1:0] rd_addr,
  output logic [7:0]     rd_data,
  output logic [NCH-1:0] valid,
  output logic [NCH-1:0] tmo
);

  state_t          state_q, state_d;
  logic [NCH-1:0]  ir_p0, s_in;
  logic [NCH-1:0]  en_q;
  logic [CHW-1:0]  ch_q;
  logic            tmo_next;
  logic            ld_scan, ld_next, store, done_d;
  ch_sel_t         first_sel, next_sel;
  logic            disch_end, meas_end, meas_tmo;
  logic [CNTW-1:0] cnt;
  logic [7:0]      result [NCH];

  function automatic logic [7:0] sat8(input logic [CNTW-1:0] c);
    logic [CNTW-1:0] s;
    s = c >> SHIFT;
    return (s > CNTW'(255)) ? 8'hff : s[7:0];
  endfunction

  // Input synchronizer stage boundary: ir_in -> ir_p0 -> s_in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_p0 <= '0;
      s_in  <= '0;
    end else begin
      ir_p0 <= ir_in;
      s_in  <= ir_p0;
    end
  end

  ir_pulse_timer #(
    .CNTW      (CNTW),
    .DISCH_CYC (DISCH_CYC),
    .WINDOW_CYC(WINDOW_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .disch_en (state_q == S_DISCH),
    .meas_en  (state_q == S_MEAS),
    .clr      (store),
    .s_bit    (s_in[ch_q]),
    .disch_end(disch_end),
    .meas_end (meas_end),
    .meas_tmo (meas_tmo),
    .cnt      (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_scan   = 1'b0;
    ld_next   = 1'b0;
    store     = 1'b0;
    done_d    = 1'b0;
    first_sel = next_ch(32'(ch_en), -1);
    next_sel  = next_ch(32'(en_q), int'(ch_q));
    unique case (state_q)
      S_IDLE: begin
        // Auto-restart waits out the done cycle so DISCH starts two cycles after done
        if ((start || (cont && !done)) && (ch_en != '0)) begin
          ld_scan = 1'b1;
          state_d = S_DISCH;
        end else if (start && (ch_en == '0)) begin
          done_d = 1'b1;
        end
      end
      S_DISCH: if (disch_end) state_d = S_MEAS;
      S_MEAS:  if (meas_end)  state_d = S_STORE;
      S_STORE: begin
        store   = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (next_sel.found) begin
          ld_next = 1'b1;
          state_d = S_DISCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= '0;
      ch_q     <= '0;
      done     <= 1'b0;
      tmo_next <= 1'b0;
    end else begin
      done <= done_d;
      if (ld_scan) begin
        en_q <= ch_en;
        ch_q <= CHW'(first_sel.idx);
      end else if (ld_next) begin
        ch_q <= CHW'(next_sel.idx);
      end
      if (meas_end) tmo_next <= meas_tmo;
    end
  end

  // Result stage boundary: visible the cycle after STORE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) result[i] <= '0;
      valid <= '0;
      tmo   <= '0;
    end else if (store) begin
      result[ch_q] <= sat8(cnt);
      valid[ch_q]  <= 1'b1;
      tmo[ch_q]    <= tmo_next;
    end
  end

  always_comb begin
    ir_oe = '0;
    if (state_q == S_DISCH) ir_oe[ch_q] = 1'b1;
  end

  assign ir_out  = ir_oe;
  assign busy    = (state_q != S_IDLE);
  assign rd_data = result[rd_addr];

endmodule

// File: doc/ir_scan_ctrl.md
# ir_scan_ctrl

Scan controller for an array of RC-discharge infrared reflectance sensors. It owns one shared pulse-width timer and steps it across `NCH` sensor pins in round-robin order. For each enabled channel it discharges the sensor, measures how long the pin stays high, and stores a scaled 8-bit distance. The processor-side logic starts scans, optionally runs them back-to-back, and reads per-channel results through a small read port.

## Interface
- `NCH`, 4: number of sensor channels
- `CHW`, 2: channel index width, equal to clog2(`NCH`)
- `CNTW`, 16: width of the pulse and phase counters
- `DISCH_CYC`, 65: discharge length in cycles (1.3 µs at 50 MHz)
- `WINDOW_CYC`, 32750: maximum measurement window in cycles
- `SHIFT`, 3: result = count >> `SHIFT`

- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: single-cycle pulse that requests one scan
- `cont` in 1: when high, a new scan begins automatically after each finished scan
- `ch_en` in `NCH`: channel enable mask, latched at scan start
- `ir_in` in `NCH`: raw sensor pin levels (asynchronous)
- `ir_oe` out `NCH`: 1 drives the pin; 0 releases it (hi-Z)
- `ir_out` out `NCH`: value driven when `ir_oe` is 1 (always 1, to discharge)
- `busy` out 1: high while a scan is in progress
- `done` out 1: one-cycle pulse at the end of each scan
- `rd_addr` in `CHW`: result read address
- `rd_data` out 8: combinational read of result[`rd_addr`]
- `valid` out `NCH`: result holds at least one measurement since reset
- `tmo` out `NCH`: last measurement of that channel hit `WINDOW_CYC`

## Operation
- Every bit of `ir_in` passes through a 2-FF synchronizer. All logic uses only the synchronized value `s_in`.
- FSM states are IDLE, DISCH, MEAS, STORE and NEXT.
- **IDLE**
  - If `start` or `cont` is high and `ch_en` is nonzero: latch `ch_en` into `en_q`, set `ch` to the lowest set bit, go to DISCH.
  - If `start` is high and `ch_en` is zero: pulse `done` on the next cycle and stay in IDLE. `busy` stays low.
- **DISCH**
  - `ir_oe[ch]=1`, `ir_out[ch]=1` for exactly `DISCH_CYC` cycles, then go to MEAS.
- **MEAS**
  - `ir_oe[ch]=0`. On each cycle where `s_in[ch]` is 1, `cnt` increments.
  - MEAS ends on the first cycle where `s_in[ch]` is 0, or when the phase count reaches `WINDOW_CYC`, whichever comes first.
  - Ending at the window limit sets `tmo_next=1`.
- **STORE**
  - result[ch] = min(`cnt` >> `SHIFT`, 255).
  - Set `valid[ch]=1` and `tmo[ch]=tmo_next`. Clear `cnt`.
- **NEXT**
  - If `en_q` has a set bit above `ch`: `ch` takes the lowest such bit, go to DISCH.
  - Otherwise pulse `done` and go to IDLE.
- Pins of non-selected channels are always released: `ir_oe=0`.
- A `start` received while `busy` is high is ignored and not queued.
- Changes to `ch_en` during a scan take effect at the next scan.
- If `cont` falls mid-scan, the current scan completes and no new scan starts.
- `cnt` saturates at its all-ones value and never wraps.
- The measured width includes the 2-cycle synchronizer delay. No compensation is applied.

## Timing
- Reset values:
  - FSM in IDLE.
  - `ir_oe`=0, `ir_out`=0.
  - `busy`=0, `done`=0.
  - All results 0, `valid`=0, `tmo`=0, `cnt`=0.
  - Synchronizers at 0.
- Reset asserted mid-operation releases every pin immediately (asynchronously) and discards any partial measurement.
- `busy` rises the cycle after the accepted `start`. It falls in the same cycle that `done` is high.
- Per-channel latency: `DISCH_CYC` + M + 2 cycles, where M is the number of MEAS cycles (at most `WINDOW_CYC`).
- In `cont` mode, the next DISCH begins 2 cycles after `done`.
- Result, `valid` and `tmo` for channel c update on the cycle after STORE(c). `rd_data` reflects the new value in that same cycle.

## Structure
- Package `ir_pkg` holds:
  - the state enum (IDLE/DISCH/MEAS/STORE/NEXT);
  - the default constants `DISCH_CYC`, `WINDOW_CYC` and `SHIFT`;
  - a function `next_ch(mask, cur)` that returns the lowest set bit above `cur`, plus a found flag.
- Sub-module `ir_pulse_timer` is the shared DISCH/MEAS phase counter and high-time counter. It provides saturation and end/timeout detection and is instantiated once.

## Test plan
Use `DISCH_CYC`=4, `WINDOW_CYC`=64 and `SHIFT`=3 for all scenarios.

- Reset, then `ch_en`=4'b0001, `start` pulse, `ir_in[0]` high for 40 cycles after release → `ir_oe[0]` high for 4 cycles, result[0]=5, `valid`=0001, `tmo`=0000, `done` pulses once.
- `ch_en`=4'b1010, `ir_in` held high → channels 1 then 3 are measured; each yields `tmo`=1 and result=8; `ir_oe[0]` and `ir_oe[2]` never go high.
- `ch_en`=0 with `start` → `done` pulses 1 cycle later; `busy` stays 0; results unchanged.
- `start` pulsed again mid-scan → ignored; exactly one `done`. Then `cont`=1 for two scans, dropped during the second → exactly 2 `done` pulses, then IDLE.
- Reset asserted during MEAS of channel 2 → all `ir_oe`=0 in the same cycle, `valid`=0, FSM in IDLE.
- `ir_in` high then low within the synchronizer window (1 cycle) → result is 0 and `tmo`=0.
